// File: rtl/cache_pkg.sv
// cache_pkg: way widths, command encoding and picker state type shared by the victim picker.
package cache_pkg;
  localparam int NUM_WAYS = 16;
  localparam int WAY_ID_W = 4;
  localparam int CMD_W = WAY_ID_W + 1;
  localparam logic [CMD_W-1:0] CMD_IDLE = 5'b0000_1;
  typedef enum logic {IDLE, SECOND} pick_state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right every cycle.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign state_o = lfsr_q;
endmodule

// File: rtl/victim_way_pick.sv
// victim_way_pick: picks victim ways on cache misses and serialises dual misses so
// at most one active-low clear command leaves per cycle.
module victim_way_pick #(
  parameter int          NUM_WAYS  = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       miss1_req,
  input  logic       miss2_req,
  input  logic       valid_in [NUM_WAYS-1:0],
  output logic       ready_out,
  output logic [4:0] way1_out,
  output logic [4:0] way2_out
);
  import cache_pkg::*;
  pick_state_t state_q, state_d;
  logic [CMD_W-1:0] way1_q, way1_d, way2_q, way2_d;
  logic [WAY_ID_W-1:0] defer_q, defer_d, v1, v2_raw, v2;
  logic [15:0] lfsr;
  logic unused_lfsr_hi;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state_o(lfsr));
  assign unused_lfsr_hi = ^lfsr[15:8];
  // Downward scans let the lowest-index invalid way win; random ids are the fallback.
  always_comb begin
    v1 = lfsr[3:0];
    v2_raw = lfsr[7:4];
    for (int i = NUM_WAYS - 1; i >= 0; i--) if (!valid_in[i]) v1 = WAY_ID_W'(i);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!valid_in[i] && WAY_ID_W'(i) != v1) v2_raw = WAY_ID_W'(i);
    v2 = (v2_raw == v1) ? v1 + WAY_ID_W'(1) : v2_raw;
  end
  always_comb begin
    state_d = IDLE;
    defer_d = defer_q;
    way1_d = {way1_q[CMD_W-1:1], 1'b1};
    way2_d = {way2_q[CMD_W-1:1], 1'b1};
    if (state_q == SECOND) way2_d = {defer_q, 1'b0};
    else if (miss1_req) begin
      way1_d = {v1, 1'b0};
      if (miss2_req) begin
        state_d = SECOND;
        defer_d = v2;
      end
    end else if (miss2_req) way2_d = {v1, 1'b0};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      defer_q <= '0;
      way1_q <= CMD_IDLE;
      way2_q <= CMD_IDLE;
    end else begin
      state_q <= state_d;
      defer_q <= defer_d;
      way1_q <= way1_d;
      way2_q <= way2_d;
    end
  assign ready_out = (state_q == IDLE);
  assign way1_out = way1_q;
  assign way2_out = way2_q;
endmodule

// File: tb/tb_victim_way_pick.sv
// tb_victim_way_pick: table vectors, directed corner sequences and a random run checked
// against a queue-based reference of the victim rules.
module tb_victim_way_pick;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic reset;
  logic miss1_req = 1'b0;
  logic miss2_req = 1'b0;
  logic valid_in [15:0];
  logic ready_out;
  logic [4:0] way1_out, way2_out;
  int total = 0;
  int passed = 0;
  logic [15:0] m_lfsr;
  bit m_sec;
  logic [3:0] m_def;
  logic [4:0] m_w1, m_w2;

  typedef struct {
    bit m1;
    bit m2;
    logic [15:0] mask;
    logic [4:0] w1a;
    logic [4:0] w2a;
    bit ra;
    logic [4:0] w1b;
    logic [4:0] w2b;
  } vec_t;
  vec_t tbl [8];

  victim_way_pick #(.NUM_WAYS(16), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .miss1_req(miss1_req), .miss2_req(miss2_req),
    .valid_in(valid_in), .ready_out(ready_out), .way1_out(way1_out), .way2_out(way2_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lnext(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  always @(posedge clk or posedge reset) m_lfsr <= reset ? SEED : lnext(m_lfsr);

  // v1 is the first invalid way, v2 the second; random ids fill in, then forced distinct.
  function automatic void pick(input logic [15:0] mask, input logic [15:0] l,
                               output logic [3:0] v1, output logic [3:0] v2);
    int inv[$];
    for (int i = 0; i < 16; i++) if (!mask[i]) inv.push_back(i);
    v1 = (inv.size() > 0) ? 4'(inv[0]) : l[3:0];
    v2 = (inv.size() > 1) ? 4'(inv[1]) : l[7:4];
    if (v2 == v1) v2 = v1 + 4'd1;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tcheck(input string nm, input logic [4:0] act, input logic [4:0] exp);
    if (exp[0]) chk(nm, 16'(act[0]), 16'h1);
    else chk(nm, 16'(act), 16'(exp));
  endtask

  task automatic cycle(input bit m1, input bit m2, input logic [15:0] mask);
    logic [3:0] v1, v2;
    @(negedge clk);
    miss1_req = m1;
    miss2_req = m2;
    for (int i = 0; i < 16; i++) valid_in[i] = mask[i];
    pick(mask, m_lfsr, v1, v2);
    m_w1[0] = 1'b1;
    m_w2[0] = 1'b1;
    if (m_sec) begin
      m_w2 = {m_def, 1'b0};
      m_sec = 1'b0;
    end else if (m1 && m2) begin
      m_w1 = {v1, 1'b0};
      m_def = v2;
      m_sec = 1'b1;
    end else if (m1) m_w1 = {v1, 1'b0};
    else if (m2) m_w2 = {v1, 1'b0};
    @(posedge clk);
    #1;
    chk("way1_out", 16'(way1_out), 16'(m_w1));
    chk("way2_out", 16'(way2_out), 16'(m_w2));
    chk("ready_out", 16'(ready_out), 16'(!m_sec));
    chk("one_clear", 16'(way1_out[0] | way2_out[0]), 16'h1);
  endtask

  // Called just after an active edge: reset lands mid-cycle and must act at once.
  task automatic reset_mid();
    #2;
    miss1_req = 1'b0;
    miss2_req = 1'b0;
    reset = 1'b1;
    #1;
    m_sec = 1'b0;
    m_w1 = 5'b00001;
    m_w2 = 5'b00001;
    chk("rst_way1", 16'(way1_out), 16'h1);
    chk("rst_way2", 16'(way2_out), 16'h1);
    chk("rst_ready", 16'(ready_out), 16'h1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r2;
    logic [15:0] mask;
    int n;
    tbl[0] = '{1'b1, 1'b0, 16'hFDDF, 5'h0A, 5'h01, 1'b1, 5'h01, 5'h01};
    tbl[1] = '{1'b0, 1'b1, 16'hFDDF, 5'h01, 5'h0A, 1'b1, 5'h01, 5'h01};
    tbl[2] = '{1'b1, 1'b1, 16'hFF7E, 5'h00, 5'h01, 1'b0, 5'h01, 5'h0E};
    tbl[3] = '{1'b1, 1'b1, 16'h0FFF, 5'h18, 5'h01, 1'b0, 5'h01, 5'h1A};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 5'h01, 5'h01, 1'b1, 5'h01, 5'h01};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 5'h01, 5'h00, 1'b1, 5'h01, 5'h01};
    tbl[6] = '{1'b1, 1'b1, 16'h0000, 5'h00, 5'h01, 1'b0, 5'h01, 5'h02};
    tbl[7] = '{1'b1, 1'b1, 16'h7FFE, 5'h00, 5'h01, 1'b0, 5'h01, 5'h1E};
    reset = 1'b1;
    for (int i = 0; i < 16; i++) valid_in[i] = 1'b1;
    m_sec = 1'b0;
    m_def = 4'd0;
    m_w1 = 5'b00001;
    m_w2 = 5'b00001;
    #1;
    chk("init_way1", 16'(way1_out), 16'h1);
    chk("init_way2", 16'(way2_out), 16'h1);
    chk("init_ready", 16'(ready_out), 16'h1);
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[k]) begin
      cycle(tbl[k].m1, tbl[k].m2, tbl[k].mask);
      tcheck("tbl_w1a", way1_out, tbl[k].w1a);
      tcheck("tbl_w2a", way2_out, tbl[k].w2a);
      chk("tbl_ra", 16'(ready_out), 16'(tbl[k].ra));
      cycle(1'b0, 1'b0, 16'hFFFF);
      tcheck("tbl_w1b", way1_out, tbl[k].w1b);
      tcheck("tbl_w2b", way2_out, tbl[k].w2b);
      chk("tbl_rb", 16'(ready_out), 16'h1);
    end
    r2 = m_lfsr[7:4];
    cycle(1'b1, 1'b1, 16'hFFF7);
    chk("dual3_w1", 16'(way1_out), 16'h06);
    chk("dual3_ready", 16'(ready_out), 16'h0);
    cycle(1'b0, 1'b0, 16'hFFFF);
    chk("dual3_w2", 16'(way2_out), 16'({(r2 == 4'd3) ? 4'd4 : r2, 1'b0}));
    chk("dual3_ready2", 16'(ready_out), 16'h1);
    cycle(1'b1, 1'b1, 16'hFF7E);
    cycle(1'b1, 1'b0, 16'hFF7E);
    chk("hold_w2", 16'(way2_out), 16'h0E);
    chk("hold_w1_quiet", 16'(way1_out[0]), 16'h1);
    cycle(1'b1, 1'b0, 16'hFF7E);
    chk("hold_w1", 16'(way1_out), 16'h00);
    cycle(1'b1, 1'b0, 16'hFDDF);
    reset_mid();
    cycle(1'b1, 1'b1, 16'hFF7E);
    reset_mid();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'hFFFF);
      chk("no_late_w2", 16'(way2_out[0]), 16'h1);
    end
    cycle(1'b1, 1'b0, 16'hFFFF);
    n = 0;
    while (m_lfsr[7:0] != 8'hFF && n < 65600) begin
      cycle(1'b0, 1'b0, 16'hFFFF);
      n++;
    end
    if (m_lfsr[7:0] != 8'hFF) begin
      total++;
      $display("FAIL wrap_search: lfsr low byte %h never reached ff", m_lfsr[7:0]);
    end else begin
      cycle(1'b1, 1'b1, 16'hFFFF);
      chk("wrap_w1", 16'(way1_out), 16'h1E);
      cycle(1'b0, 1'b0, 16'hFFFF);
      chk("wrap_w2", 16'(way2_out), 16'h00);
    end
    for (int i = 0; i < 1000; i++) begin
      mask = ($urandom_range(0, 3) == 0) ? 16'hFFFF
           : (16'($urandom) | 16'($urandom) | 16'($urandom));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mask);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
